uart_rx: RTL and testbench

Serial receiver paired with `uart_tx` on the far end of the line. It oversamples the incoming `rx` line at 16 ticks per bit using the shared baud-tick generator. It deserialises 5–8 data bits, an optional parity bit, and 1–2 stop bits, using the same framing configuration inputs as the transmitter. Each received character is presented in a holding register with a valid/read handshake, parity, framing and overrun flags, and an `rts_n` flow-control output that feeds the remote transmitter's `cts_n`.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Holding-register side of the UART receiver: received character, status flags,
// read strobe and the rts_n flow-control line.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_en;
    logic       parity_error;
    logic       frame_error;
    logic       overrun_error;
    logic       rts_n;

    modport master (
        output rx_data, rx_valid, parity_error, frame_error, overrun_error, rts_n,
        input  rd_en
    );

    modport slave (
        input  rx_data, rx_valid, parity_error, frame_error, overrun_error, rts_n,
        output rd_en
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 5-8 data bits, optional parity, 1-2 stop bits,
// single-entry holding register with parity/framing/overrun flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | confirming the start bit at its mid-point
// DATA   | shifting in data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling 1 or 2 stop bits, then completing the frame
module uart_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    uart_rx_if.master  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic       rx_meta;
    logic       rxs;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [1:0] cfg_dbn;
    logic       cfg_stop;
    logic       cfg_pen;
    logic       cfg_ptype;
    logic       par_err;
    logic       frm_err;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       ferr_q;
    logic       ovr_q;
    logic       last_data;
    logic       frame_done;

    always_comb begin
        last_data  = (bit_cnt == (3'd4 + {1'b0, cfg_dbn}));
        frame_done = tick && (state == STOP) && (tick_cnt == 4'd15) &&
                     (bit_cnt == {2'b00, cfg_stop});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            cfg_dbn   <= 2'd0;
            cfg_stop  <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_ptype <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        tick_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        if (!rxs) begin
                            // configuration is frozen here for the whole frame
                            cfg_dbn   <= data_bit_num;
                            cfg_stop  <= stop_bit_num;
                            cfg_pen   <= parity_en;
                            cfg_ptype <= parity_type;
                            tick_cnt  <= 4'd0;
                            bit_cnt   <= 3'd0;
                            shreg     <= 8'd0;
                            par_err   <= 1'b0;
                            frm_err   <= 1'b0;
                            state     <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg[bit_cnt] <= rxs;
                        if (last_data) begin
                            bit_cnt <= 3'd0;
                            state   <= cfg_pen ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        // odd parity fails on an even XOR, even parity on an odd XOR
                        par_err <= (((^shreg) ^ rxs) == cfg_ptype);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        frm_err <= frm_err | ~rxs;
                        if (bit_cnt == {2'b00, cfg_stop}) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (frame_done) begin
            data_q  <= shreg;
            perr_q  <= cfg_pen & par_err;
            ferr_q  <= frm_err | ~rxs;
            valid_q <= 1'b1;
            // a simultaneous read consumes the old character, so no overrun
            if (valid_q) begin
                ovr_q <= ~bus.rd_en;
            end
        end else if (bus.rd_en && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.frame_error   = ferr_q;
    assign bus.overrun_error = ovr_q;
    assign bus.rts_n         = valid_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives framed characters tick by tick and checks the holding
// register every cycle against a frame-level model of the receiver.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bit_num = 2'd3;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;

    uart_rx_if bus();

    uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .rx           (rx),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tick_idx = 0;
    int force_rd_tick = -1;
    bit rand_rd = 1'b0;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t q[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       m_pe = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;

    // Holding-register model: a queued character lands on its scheduled tick
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_pe    <= 1'b0;
            m_fe    <= 1'b0;
            m_ovr   <= 1'b0;
        end else if (tick && q.size() > 0 && q[0].t == tick_idx) begin
            m_data  <= q[0].d;
            m_pe    <= q[0].pe;
            m_fe    <= q[0].fe;
            m_valid <= 1'b1;
            if (m_valid) m_ovr <= !bus.rd_en;
            void'(q.pop_front());
        end else if (bus.rd_en && m_valid) begin
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.rx_valid, bus.rx_data, bus.parity_error, bus.frame_error,
                 bus.overrun_error, bus.rts_n} !==
                {m_valid, m_data, m_pe, m_fe, m_ovr, m_valid}) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got v=%b d=%h pe=%b fe=%b ov=%b rts_n=%b exp v=%b d=%h pe=%b fe=%b ov=%b rts_n=%b",
                         $time, bus.rx_valid, bus.rx_data, bus.parity_error, bus.frame_error,
                         bus.overrun_error, bus.rts_n, m_valid, m_data, m_pe, m_fe, m_ovr, m_valid);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp_v);
        end
    endtask

    // One 16x period: rx settles through the synchroniser before the tick cycle
    task automatic step(input logic v);
        @(negedge clk);
        rx = v;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        bus.rd_en = (rand_rd && ($urandom_range(0, 19) == 0)) || (tick_idx == force_rd_tick);
        @(negedge clk);
        tick = 1'b0;
        bus.rd_en = 1'b0;
        tick_idx++;
    endtask

    task automatic do_read();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] dbn, input logic sb, input logic pen,
                              input logic pt, input logic [7:0] d, input logic bad_par,
                              input logic s0, input logic s1, input bit scramble,
                              input int idle);
        int         nd;
        logic [7:0] dm;
        logic       pbit;
        exp_t       e;
        nd = 5 + int'(dbn);
        dm = d & 8'((1 << nd) - 1);
        pbit = (^dm) ^ !pt ^ bad_par;
        data_bit_num = dbn;
        stop_bit_num = sb;
        parity_en    = pen;
        parity_type  = pt;
        e.t  = tick_idx + 8 + 16 * (nd + int'(pen) + (sb ? 2 : 1));
        e.d  = dm;
        e.pe = pen & bad_par;
        e.fe = !s0 || (sb && !s1);
        q.push_back(e);
        repeat (16) step(1'b0);
        if (scramble) begin
            data_bit_num = 2'($urandom);
            stop_bit_num = 1'($urandom);
            parity_en    = 1'($urandom);
            parity_type  = 1'($urandom);
        end
        for (int i = 0; i < nd; i++) repeat (16) step(dm[i]);
        if (pen) repeat (16) step(pbit);
        repeat (16) step(s0);
        if (sb) repeat (16) step(s1);
        repeat (idle) step(1'b1);
    endtask

    initial begin
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", bus.rx_valid, 0);
        chk("reset_rts_n", bus.rts_n, 0);
        chk("reset_data", bus.rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b1);

        // 8N1 0xA5
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("a5_data", bus.rx_data, 8'hA5);
        chk("a5_valid", bus.rx_valid, 1);
        chk("a5_rts_n", bus.rts_n, 1);
        chk("a5_flags", {bus.parity_error, bus.frame_error, bus.overrun_error}, 0);
        do_read();
        chk("a5_read_valid", bus.rx_valid, 0);
        chk("a5_read_rts_n", bus.rts_n, 0);

        // 7E2 0x55 with good then bad parity
        send_frame(2'd2, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("7e2_good_pe", bus.parity_error, 0);
        do_read();
        send_frame(2'd2, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        chk("7e2_bad_pe", bus.parity_error, 1);
        chk("7e2_bad_data", bus.rx_data, 8'h55);
        do_read();

        // 5O1 0x13 with stop bit low, then a good frame
        send_frame(2'd0, 1'b0, 1'b1, 1'b0, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        chk("5o1_data", bus.rx_data, 8'h13);
        chk("5o1_fe", bus.frame_error, 1);
        do_read();
        send_frame(2'd0, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("5o1_fe_clear", bus.frame_error, 0);
        do_read();

        // 4-tick glitch on the idle line
        repeat (4) step(1'b0);
        repeat (20) step(1'b1);
        chk("glitch_valid", bus.rx_valid, 0);

        // overrun
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("ovr_data", bus.rx_data, 8'h22);
        chk("ovr_flag", bus.overrun_error, 1);
        do_read();
        chk("ovr_read_valid", bus.rx_valid, 0);
        chk("ovr_read_flag", bus.overrun_error, 0);

        // read on the completion tick of a second character
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        force_rd_tick = tick_idx + 8 + 16 * 9;
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        force_rd_tick = -1;
        chk("simul_data", bus.rx_data, 8'h33);
        chk("simul_valid", bus.rx_valid, 1);
        chk("simul_ovr", bus.overrun_error, 0);

        // reset during data bit 3 of 0xFF, then 0x3C
        data_bit_num = 2'd3; stop_bit_num = 1'b0; parity_en = 1'b0;
        repeat (16) step(1'b0);
        repeat (16 * 3 + 8) step(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_rts_n", bus.rts_n, 0);
        rst_n = 1'b1;
        repeat (20) step(1'b1);
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("post_rst_data", bus.rx_data, 8'h3C);
        do_read();

        // randomized frames, mid-frame config scrambling and random reads
        rand_rd = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 6)) step(1'b0);
                repeat (12) step(1'b1);
            end
            send_frame(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                       1'b1, int'($urandom_range(2, 6)));
            if ($urandom_range(0, 2) == 0) do_read();
        end
        rand_rd = 1'b0;
        repeat (4) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
